// File: rtl/matrix_job_master.sv
// ---------------------------------------------------------------------------
// matrix_job_master
//
// Bus master (M0) for the matrix-multiply subsystem. It takes a job as a word
// stream (N_WORDS A words, then N_WORDS B words), writes them into the A and B
// RAMs, kicks the engine through its control register, waits for the engine
// interrupt, clears it, then reads the N_WORDS result words back and streams
// them out under consumer backpressure.
//
// Ports
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   start                 one-cycle job kick, ignored while busy
//   in_valid/in_data/in_ready    job word stream (A words first, then B)
//   out_valid/out_data/out_ready result word stream, index 0 first
//   busy                  high from accepted start until DONE exits
//   done                  one-cycle pulse after the last result word is taken
//   err                   sticky WAIT_INT timeout flag
//   M0_req/M0_wr/M0_address/M0_dout, M0_grant, M_din   bus master port
//   m_interrupt           engine completion interrupt (level)
//
// Build option
//   MATRIX_JOB_TIMEOUT_EN  when defined, WAIT_INT gives up after TIMEOUT
//                          cycles, sets err and skips the read phase. When
//                          undefined, WAIT_INT waits forever and err is 0.
// ---------------------------------------------------------------------------
module matrix_job_master #(
  parameter int unsigned N_WORDS     = 16,
  parameter logic [7:0]  A_BASE      = 8'h10,
  parameter logic [7:0]  B_BASE      = 8'h20,
  parameter logic [7:0]  R_BASE      = 8'h40,
  parameter logic [7:0]  CTRL_ADDR   = 8'h00,
  parameter logic [31:0] CTRL_START  = 32'h0000_0001,
  parameter logic [7:0]  INTCLR_ADDR = 8'h01
`ifdef MATRIX_JOB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT   = 1024
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        M0_req,
  output logic        M0_wr,
  output logic [7:0]  M0_address,
  output logic [31:0] M0_dout,
  input  logic        M0_grant,
  input  logic [31:0] M_din,
  input  logic        m_interrupt
);

  localparam int unsigned   CW   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT_INT,
    S_CLR_INT, S_RD_ADDR, S_RD_CAP, S_RD_HOLD, S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic [31:0]   out_data_q;
  logic          busy_q;
  logic          done_q;

`ifdef MATRIX_JOB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // NOTE: every state register is updated with non-blocking assignments so
  // all of them see the same pre-edge values; blocking here would let later
  // statements observe half-updated state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MATRIX_JOB_TIMEOUT_EN
      wait_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD_A;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef MATRIX_JOB_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        // The word is on the bus this cycle; it counts only when granted.
        S_LOAD_A, S_LOAD_B: begin
          if (in_valid && M0_grant) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_START: begin
          if (M0_grant) begin
            state_q <= S_WAIT_INT;
`ifdef MATRIX_JOB_TIMEOUT_EN
            wait_q  <= '0;
`endif
          end
        end
        S_WAIT_INT: begin
          if (m_interrupt) begin
            state_q <= S_CLR_INT;
`ifdef MATRIX_JOB_TIMEOUT_EN
          end else if (wait_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wait_q  <= wait_q + 1'b1;
`endif
          end
        end
        S_CLR_INT: begin
          if (M0_grant) begin
            state_q <= S_RD_ADDR;
            cnt_q   <= '0;
          end
        end
        S_RD_ADDR: begin
          if (M0_grant) state_q <= S_RD_CAP;
        end
        // Read data belongs to the previous granted address cycle, but is
        // only valid if the bus is still ours; otherwise reissue the address.
        S_RD_CAP: begin
          if (M0_grant) begin
            out_data_q  <= M_din;
            out_valid_q <= 1'b1;
            state_q     <= S_RD_HOLD;
          end else begin
            state_q <= S_RD_ADDR;
          end
        end
        S_RD_HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            if (cnt_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_RD_ADDR;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Bus drive is a pure function of the current state and the stream inputs,
  // so a denied request simply repeats the same address/data next cycle.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    M0_req     = 1'b0;
    M0_wr      = 1'b0;
    M0_address = '0;
    M0_dout    = '0;
    in_ready   = 1'b0;
    unique case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        M0_req     = 1'b1;
        M0_wr      = in_valid;
        M0_address = ((state_q == S_LOAD_A) ? A_BASE : B_BASE) + 8'(cnt_q);
        M0_dout    = in_data;
        in_ready   = M0_grant;
      end
      S_START: begin
        M0_req     = 1'b1;
        M0_wr      = 1'b1;
        M0_address = CTRL_ADDR;
        M0_dout    = CTRL_START;
      end
      S_CLR_INT: begin
        M0_req     = 1'b1;
        M0_wr      = 1'b1;
        M0_address = INTCLR_ADDR;
      end
      S_RD_ADDR, S_RD_CAP: begin
        M0_req     = 1'b1;
        M0_address = R_BASE + 8'(cnt_q);
      end
      default: ;
    endcase
  end

endmodule
